// File: rtl/hopfield_pkg.sv
// rtl/hopfield_pkg.sv - shared constants and state type for the Hopfield neuron array
// Purpose: network size, Q8.8 format limits and the integrator FSM state type.
// Ports: none (package).
package hopfield_pkg;

  localparam int N_NEURONS = 7;       // 6 RS excitatory + 1 FS inhibitory
  localparam int N_EXC     = 6;       // indices 0..N_EXC-1 are excitatory
  localparam int Q_W       = 16;      // Q8.8 word width
  localparam int Q_FRAC    = 8;       // fractional bits
  localparam int SAT_MAX   = 32767;
  localparam int SAT_MIN   = -32768;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } integ_state_t;

endpackage

// File: rtl/sat_q88.sv
// rtl/sat_q88.sv - clamp a wide signed accumulator to a signed Q8.8 word
// Purpose: combinational saturation, shared by the integrator and the neuron update stage.
// Ports:
//   acc - signed ACC_W-bit accumulator value (ACC_W must be > 16)
//   q   - signed 16-bit result clamped to SAT_MIN..SAT_MAX
module sat_q88
  import hopfield_pkg::*;
#(
  parameter int ACC_W = 20
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [Q_W-1:0]   q
);

  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(SAT_MAX);
  localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(SAT_MIN);

  always_comb begin
    q = acc[Q_W-1:0];
    if (acc > MAX_V) begin
      q = 16'sh7FFF;
    end else if (acc < MIN_V) begin
      q = 16'sh8000;
    end
  end

endmodule

// File: rtl/synaptic_integrator.sv
// rtl/synaptic_integrator.sv - serial synaptic current integrator, one weight per cycle
// Purpose: on start, computes currents[i] = sat16(sum_j weight[i][j] * spk[j], j != i)
//   with a single adder, walking (i,j) row-major over N*N cycles.
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset
//   spikes        - neuron spike vector, latched on the accepted start edge
//   weights_flat  - Q8.8 weights, weight[i][j] at [(i*N+j)*16 +: 16], read live
//   start, abort  - begin a pass (IDLE only) / cancel the pass in progress
//   busy, done    - pass in progress / one-cycle completion pulse
//   currents_flat - Q8.8 current per neuron, neuron i at [i*16 +: 16]
module synaptic_integrator
  import hopfield_pkg::*;
#(
  parameter int N     = N_NEURONS,
  parameter int ACC_W = 20
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N-1:0]         spikes,
  input  logic [N*N*Q_W-1:0]   weights_flat,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic [N*Q_W-1:0]     currents_flat
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  integ_state_t             state, next_state;
  logic [N-1:0]             spk_q;
  logic [IW-1:0]            i_q, j_q;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  sum;
  logic signed [Q_W-1:0]    w_sel;
  logic signed [Q_W-1:0]    sat_out;
  logic                     last_pair;

  assign last_pair = (i_q == LAST) && (j_q == LAST);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

  // Single MAC path: the weight is added only for spiking presynaptic
  // neurons and never for the self-connection.
  always_comb begin
    w_sel = weights_flat[(int'(i_q) * N + int'(j_q)) * Q_W +: Q_W];
    sum   = acc;
    if (spk_q[j_q] && (i_q != j_q)) begin
      sum = acc + ACC_W'(w_sel);
    end
  end

  sat_q88 #(.ACC_W(ACC_W)) u_sat (
    .acc (sum),
    .q   (sat_out)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (start) next_state = ST_ACCUM;
      ST_ACCUM: begin
        if (abort) begin
          next_state = ST_IDLE;
        end else if (last_pair) begin
          next_state = ST_DONE;
        end
      end
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spk_q         <= '0;
      i_q           <= '0;
      j_q           <= '0;
      acc           <= '0;
      currents_flat <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            spk_q <= spikes;
            i_q   <= '0;
            j_q   <= '0;
            acc   <= '0;
          end
        end
        ST_ACCUM: begin
          // abort wins over the row write that would happen on this edge
          if (!abort) begin
            if (j_q == LAST) begin
              currents_flat[int'(i_q) * Q_W +: Q_W] <= sat_out;
              acc <= '0;
              j_q <= '0;
              i_q <= (i_q == LAST) ? '0 : i_q + 1'b1;
            end else begin
              acc <= sum;
              j_q <= j_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/synaptic_integrator.md
SYNAPTIC_INTEGRATOR -- requirements
Module: synaptic_integrator

Interface
REQ-001 Parameter N, default 7, total neuron count; indices 0..5 are RS (excitatory) and index 6 is FS (inhibitory).
REQ-002 Parameter ACC_W, default 20, internal accumulator width in bits.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 spikes  input  N  current spike vector from the neuron array.
REQ-006 weights_flat  input  N*N*16  signed Q8.8 weights; weight[i][j] (j→i) occupies bits [(i*N+j)*16 +: 16].
REQ-007 start  input  1  request one integration pass.
REQ-008 abort  input  1  synchronous cancel of the pass in progress.
REQ-009 busy  output  1  high while a pass is in progress.
REQ-010 done  output  1  one-cycle pulse when currents_flat is updated.
REQ-011 currents_flat  output  N*16  signed Q8.8 synaptic current per neuron; neuron i occupies bits [i*16 +: 16].

Function
REQ-012 States: IDLE, ACCUM, DONE. Encoding is free.
REQ-013 IDLE→ACCUM occurs on a clk edge with start=1. On that edge the block SHALL latch spikes into spk_q and clear i, j and the accumulator.
REQ-014 start SHALL be ignored in ACCUM and DONE; there is no queueing.
REQ-015 In ACCUM, each cycle processes exactly one (i,j) pair: acc += sign-extended weight[i][j] if spk_q[j]=1 and i≠j, else acc += 0.
REQ-016 j increments each cycle. When j=N-1, the block SHALL write currents[i] = sat16(acc + term), clear acc, set j=0, and increment i.
REQ-017 sat16 clamps to the range -32768..32767. Accumulation uses ACC_W bits and SHALL NOT wrap internally.
REQ-018 After the pair (N-1,N-1) the block SHALL enter DONE, assert done for exactly one cycle, then return to IDLE.
REQ-019 Latency: a start accepted at edge k yields done=1 during the cycle following edge k+N*N (49 ACCUM cycles at N=7).
REQ-020 busy=1 in ACCUM and DONE; busy=0 in IDLE.
REQ-021 weights_flat is sampled live each ACCUM cycle. The driver SHALL hold it stable (learning disabled) while busy=1; the block does not check this.
REQ-022 spikes changing during ACCUM SHALL NOT affect the pass, because only spk_q is used.
REQ-023 currents_flat holds its value between passes. Rows are updated progressively during a pass and are fully valid only when done=1.
REQ-024 abort=1 in ACCUM or DONE SHALL return the block to IDLE on the next edge with done=0. Rows already written remain written. abort takes priority over the completion of a pass on the same edge.
REQ-025 abort in IDLE has no effect. If start=1 and abort=1 coincide in IDLE, start wins.

Reset
REQ-026 reset_n=0 SHALL asynchronously force state=IDLE, busy=0, done=0, currents_flat=0, acc=0, i=0, j=0 and spk_q=0.
REQ-027 Reset asserted mid-pass discards the pass. After release the block idles until a new start.

Structure
REQ-028 Shared package hopfield_pkg holds N_NEURONS=7, N_EXC=6, Q_W=16, Q_FRAC=8, SAT_MAX=32767, SAT_MIN=-32768 and the state enum type.
REQ-029 Saturation is a combinational sub-module sat_q88 (ACC_W-bit input, 16-bit output), reusable by the neuron update stage.
REQ-030 The block uses one adder datapath only, with no N-wide parallel MAC.

Verification
REQ-031 All weights=0x0100 (1.0), spikes=7'h7F, start pulse → done at start+49 edges; every current = 0x0600 (6.0).
REQ-032 weight[0][1]=0x7FFF, weight[0][2]=0x7FFF, all others 0, spikes=7'h06 → current[0]=0x7FFF (saturated); currents 1..6 = 0.
REQ-033 All weights=0x8000, spikes=7'h7F → every current = 0x8000 (negative saturation).
REQ-034 Start with spikes=7'h01, toggle spikes to 7'h7F mid-pass, second start pulse at cycle 10 → result uses 7'h01 only; the second start is ignored and done pulses once.
REQ-035 Abort at ACCUM cycle 20 → busy falls next edge, no done, rows 0..1 written and rows 2..6 retain prior values. Repeat the test with reset_n low at cycle 20 → all currents = 0 immediately.
REQ-036 weight[i][i]=0x0100 for all i, others 0, spikes=7'h7F → all currents = 0 (self-terms excluded).
